seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised W-bit MIPS-style ALU for the midterm datapath, replacing the per-bit slice chain as the execute-stage arithmetic unit. Single-cycle registered AND/OR/ADD/SUB/SLT/SRL, a multi-cycle unsigned multiply (MULTU) into internal HI/LO registers, and MFHI/MFLO reads. A start/busy/valid handshake lets the control FSM stall during multiplication.

## Interface
- W, default 32: operand/result width, ≥ 4.
- SHW, default $clog2(W): shift-amount width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only when busy=0.
- ctl  in  6  function code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MULTU 011001 (25), MFHI 010000, MFLO 010010.
- a  in  W  operand A.
- b  in  W  operand B; SRL shifts b.
- shamt  in  SHW  SRL shift amount.
- result  out  W  registered result, held until next accepted op.
- zero  out  1  result == 0, registered with result.
- ovf  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- illegal  out  1  pulses with valid when ctl is not a listed code.
- busy  out  1  multiply in progress; start ignored.
- valid  out  1  one-cycle pulse: result/flags updated.

## Operation
- States: IDLE, MUL.
- IDLE, start=1, ctl≠MULTU: compute, register result/zero/ovf/illegal, pulse valid; stay IDLE.
- IDLE, start=1, ctl=MULTU: latch a as multiplicand, b as multiplier, clear 2W-bit accumulator, counter = W-1, go MUL.
- MUL: each cycle, if multiplier LSB = 1 add multiplicand to upper half (W+1-bit carry kept), shift {carry, acc} right 1; counter decrements. When counter = 0 and the iteration completes: HI ← acc[2W-1:W], LO ← acc[W-1:0], result ← LO, zero from LO, ovf=0, valid pulse, go IDLE.
- Arithmetic: ADD/SUB are two's complement, sum truncated to W. ovf = (sign A == sign B') && (sign sum ≠ sign A), where B' = ~b for SUB. SLT result = {W-1 zeros, sum[W-1] ^ ovf} of a−b; ovf output 0. SRL logical, zero-fill; shamt ≥ W gives 0. MFHI/MFLO return HI/LO, single cycle.
- Unknown ctl: result 0, zero 1, illegal 1, valid pulse; HI/LO untouched.
- start while busy: ignored, no queueing; operands may change freely.
- Reset mid-MUL: abort, HI/LO keep reset value 0, no valid.

## Timing
- Reset values: result 0, zero 1, ovf 0, illegal 0, busy 0, valid 0, HI 0, LO 0, state IDLE.
- Single-cycle op accepted in cycle N: valid=1 and new result in N+1.
- MULTU accepted in cycle N: busy=1 in N+1..N+W; valid=1, busy=0, HI/LO/result new in N+W+1. Earliest next accept: N+W+1.
- MFHI issued in the valid cycle of a MULTU returns the new HI (HI written before the cycle).
- Back-to-back single-cycle ops: one per cycle, valid high every cycle.
- Outputs are all register-driven; no combinational path from inputs to outputs.

## Structure
- Package alu_pkg: the nine 6-bit function-code constants, state enum {IDLE, MUL}.
- One sub-module: multu_seq (multiplicand/multiplier/accumulator/counter, load/step/done), keeping the shift-add datapath out of the top.
- Top holds combinational logic unit, result registers, HI/LO, FSM.

## Test plan
- Reset: assert reset mid-run -> result 0, zero 1, busy 0, valid 0, HI=LO=0 immediately (async).
- ADD 0x7FFFFFFF + 1 -> result 0x80000000, ovf 1, valid in N+1; SUB 5−5 -> result 0, zero 1, ovf 0.
- SLT a=0x80000000, b=1 -> result 1; a=1, b=0xFFFFFFFF -> result 0; SRL b=0xF0000000, shamt 4 -> 0x0F000000; shamt 31 -> 1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy 32 cycles, valid at N+33, LO=result 0x00000001; MFHI -> 0xFFFFFFFE, MFLO -> 0x00000001.
- start pulsed with ADD during busy -> ignored, no extra valid, MULTU result unchanged; reset at N+10 of MULTU -> no valid, MFHI returns 0.
- ctl 111111 -> result 0, zero 1, illegal 1 for one cycle; HI/LO from prior MULTU 3×4 (LO=12) unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: function codes and FSM state encoding.
package alu_pkg;

  localparam int unsigned CTL_W = 6;

  localparam logic [CTL_W-1:0] CTL_AND   = 6'b100100;
  localparam logic [CTL_W-1:0] CTL_OR    = 6'b100101;
  localparam logic [CTL_W-1:0] CTL_ADD   = 6'b100000;
  localparam logic [CTL_W-1:0] CTL_SUB   = 6'b100010;
  localparam logic [CTL_W-1:0] CTL_SLT   = 6'b101010;
  localparam logic [CTL_W-1:0] CTL_SRL   = 6'b000010;
  localparam logic [CTL_W-1:0] CTL_MULTU = 6'b011001;
  localparam logic [CTL_W-1:0] CTL_MFHI  = 6'b010000;
  localparam logic [CTL_W-1:0] CTL_MFLO  = 6'b010010;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the control FSM (master) and the execute ALU (slave).
interface seq_alu_if #(
  parameter int unsigned W   = 32,
  parameter int unsigned SHW = $clog2(W)
);
  logic           start;
  logic [5:0]     ctl;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   result;
  logic           zero;
  logic           ovf;
  logic           illegal;
  logic           busy;
  logic           valid;

  modport master (
    output start, ctl, a, b, shamt,
    input  result, zero, ovf, illegal, busy, valid
  );

  modport slave (
    input  start, ctl, a, b, shamt,
    output result, zero, ovf, illegal, busy, valid
  );
endinterface

// File: rtl/multu_seq.sv
// Radix-2 shift-add unsigned multiplier: one partial product per step, W steps per product.
module multu_seq #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   mcand_in,
  input  logic [W-1:0]   mplier_in,
  output logic [2*W-1:0] prod_c,
  output logic           last_c
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     upper_sum;
  logic [2*W-1:0] acc_step;

  // Add into the upper half keeping the carry, then shift {carry, acc} right one place.
  always_comb begin
    upper_sum = {1'b0, acc_q[2*W-1:W]};
    if (mplier_q[0]) begin
      upper_sum = upper_sum + {1'b0, mcand_q};
    end
    acc_step = {upper_sum, acc_q[W-1:1]};
  end

  assign prod_c = acc_step;
  assign last_c = (cnt_q == '0);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = mcand_in;
      mplier_d = mplier_in;
      acc_d    = '0;
      cnt_d    = CW'(W - 1);
    end else if (step) begin
      mplier_d = {1'b0, mplier_q[W-1:1]};
      acc_d    = acc_step;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU: registered single-cycle ops plus a multi-cycle MULTU into HI/LO.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned SHW = $clog2(W)
) (
  input  logic       clk,
  input  logic       reset,
  seq_alu_if.slave   bus
);

  state_e         state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
  logic           illegal_q, illegal_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  logic [SHW-1:0] shamt;
  logic           is_sub;
  logic [W-1:0]   b_eff;
  logic [W-1:0]   sum;
  logic           add_ovf;
  logic [W-1:0]   alu_res;
  logic           alu_ovf;
  logic           alu_ill;

  logic           mul_load;
  logic           mul_step;
  logic [2*W-1:0] mul_prod_c;
  logic           mul_last_c;

  assign shamt = bus.shamt;

  // Shared adder: SUB and SLT both compute a - b as a + ~b + 1.
  always_comb begin
    is_sub  = (bus.ctl == CTL_SUB) || (bus.ctl == CTL_SLT);
    b_eff   = is_sub ? ~bus.b : bus.b;
    sum     = bus.a + b_eff + W'(is_sub);
    add_ovf = (bus.a[W-1] == b_eff[W-1]) && (sum[W-1] != bus.a[W-1]);
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.ctl)
      CTL_AND:   alu_res = bus.a & bus.b;
      CTL_OR:    alu_res = bus.a | bus.b;
      CTL_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      CTL_SUB: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      CTL_SLT:   alu_res = W'(sum[W-1] ^ add_ovf);
      CTL_SRL:   alu_res = bus.b >> shamt;
      CTL_MFHI:  alu_res = hi_q;
      CTL_MFLO:  alu_res = lo_q;
      CTL_MULTU: alu_res = '0;
      default:   alu_ill = 1'b1;
    endcase
  end

  // Next-state and output registers; valid and illegal are single-cycle pulses.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = 1'b0;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.ctl == CTL_MULTU) begin
            mul_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = MUL;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            ovf_d     = alu_ovf;
            illegal_d = alu_ill;
            valid_d   = 1'b1;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last_c) begin
          hi_d     = mul_prod_c[2*W-1:W];
          lo_d     = mul_prod_c[W-1:0];
          result_d = mul_prod_c[W-1:0];
          zero_d   = (mul_prod_c[W-1:0] == '0);
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  multu_seq #(.W(W)) u_multu (
    .clk       (clk),
    .reset     (reset),
    .load      (mul_load),
    .step      (mul_step),
    .mcand_in  (bus.a),
    .mplier_in (bus.b),
    .prod_c    (mul_prod_c),
    .last_c    (mul_last_c)
  );

  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.ovf     = ovf_q;
  assign bus.illegal = illegal_q;
  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table of single-cycle ops plus MULTU/reset sequences.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned SHW = 5;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  seq_alu_if #(.W(W), .SHW(SHW)) bus ();

  seq_alu #(.W(W), .SHW(SHW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]     ctl;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [SHW-1:0] sh;
    logic [W-1:0]   res;
    logic           z;
    logic           o;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SHW-1:0] sh);
    bus.ctl   = c;
    bus.a     = a;
    bus.b     = b;
    bus.shamt = sh;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called in cycle N+1 after a MULTU accept; returns the cycle offset where valid rose.
  task automatic wait_valid(output int cyc, output logic busy_ok);
    cyc     = 1;
    busy_ok = 1'b1;
    while (!bus.valid && cyc < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int   cyc;
    logic busy_ok;
    int   vcount;
    int   first;

    n_tests = 0;
    n_fail  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.ctl   = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.shamt = '0;

    vecs[0]  = '{CTL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1};
    vecs[1]  = '{CTL_SUB, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{CTL_SLT, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0};
    vecs[3]  = '{CTL_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
    vecs[4]  = '{CTL_SRL, 32'h1234_5678, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0, 1'b0};
    vecs[5]  = '{CTL_SRL, 32'h0000_0000, 32'hF000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6]  = '{CTL_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1'b0};
    vecs[7]  = '{CTL_OR,  32'h0F0F_0000, 32'h0000_00F0, 5'd0,  32'h0F0F_00F0, 1'b0, 1'b0};
    vecs[8]  = '{CTL_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[9]  = '{CTL_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
    vecs[10] = '{CTL_SLT, 32'h0000_0005, 32'h0000_0007, 5'd0,  32'h0000_0001, 1'b0, 1'b0};
    vecs[11] = '{CTL_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0,  32'h0000_0000, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result",  64'(bus.result),  64'h0);
    chk("rst_zero",    64'(bus.zero),    64'h1);
    chk("rst_ovf",     64'(bus.ovf),     64'h0);
    chk("rst_illegal", 64'(bus.illegal), 64'h0);
    chk("rst_busy",    64'(bus.busy),    64'h0);
    chk("rst_valid",   64'(bus.valid),   64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // start held high across the table: one accepted op and one valid per cycle
    for (int i = 0; i < 12; i++) begin
      bus.ctl   = vecs[i].ctl;
      bus.a     = vecs[i].a;
      bus.b     = vecs[i].b;
      bus.shamt = vecs[i].sh;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_result", i), 64'(bus.result),  64'(vecs[i].res));
      chk($sformatf("vec%0d_zero", i),   64'(bus.zero),    64'(vecs[i].z));
      chk($sformatf("vec%0d_ovf", i),    64'(bus.ovf),     64'(vecs[i].o));
      chk($sformatf("vec%0d_valid", i),  64'(bus.valid),   64'h1);
      chk($sformatf("vec%0d_illegal", i), 64'(bus.illegal), 64'h0);
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", 64'(bus.valid), 64'h0);
    chk("idle_hold",  64'(bus.result), 64'h0);

    // MULTU max x max
    issue(CTL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    chk("mul_busy_n1", 64'(bus.busy), 64'h1);
    wait_valid(cyc, busy_ok);
    chk("mul_busy_held", 64'(busy_ok), 64'h1);
    chk("mul_latency",   64'(cyc),     64'd33);
    chk("mul_lo_result", 64'(bus.result), 64'h1);
    chk("mul_busy_done", 64'(bus.busy),   64'h0);
    chk("mul_ovf",       64'(bus.ovf),    64'h0);
    issue(CTL_MFHI, 32'h0, 32'h0, 5'd0);
    chk("mfhi_max", 64'(bus.result), 64'hFFFF_FFFE);
    chk("mfhi_valid", 64'(bus.valid), 64'h1);
    issue(CTL_MFLO, 32'h0, 32'h0, 5'd0);
    chk("mflo_max", 64'(bus.result), 64'h1);

    // MULTU 3x4 with an ADD request mid-multiply that must be dropped
    issue(CTL_MULTU, 32'd3, 32'd4, 5'd0);
    vcount = 0;
    first  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.valid) begin
        vcount++;
        if (first == 0) first = k;
      end
      bus.start = (k == 5);
      bus.ctl   = CTL_ADD;
      bus.a     = 32'd100 + 32'(k);
      bus.b     = 32'd1;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    chk("busy_ign_first", 64'(first),  64'd33);
    chk("busy_ign_count", 64'(vcount), 64'd1);
    chk("busy_ign_result", 64'(bus.result), 64'd12);

    // Illegal code leaves HI/LO intact
    issue(6'b111111, 32'h1234, 32'h5678, 5'd0);
    chk("ill_result",  64'(bus.result),  64'h0);
    chk("ill_zero",    64'(bus.zero),    64'h1);
    chk("ill_illegal", 64'(bus.illegal), 64'h1);
    chk("ill_valid",   64'(bus.valid),   64'h1);
    @(posedge clk);
    #1;
    chk("ill_pulse", 64'(bus.illegal), 64'h0);
    issue(CTL_MFHI, 32'h0, 32'h0, 5'd0);
    chk("ill_hi_kept", 64'(bus.result), 64'h0);
    issue(CTL_MFLO, 32'h0, 32'h0, 5'd0);
    chk("ill_lo_kept", 64'(bus.result), 64'd12);

    // Reset ten cycles into a multiply
    issue(CTL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", 64'(bus.busy), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_result", 64'(bus.result), 64'h0);
    chk("arst_zero",   64'(bus.zero),   64'h1);
    chk("arst_busy",   64'(bus.busy),   64'h0);
    chk("arst_valid",  64'(bus.valid),  64'h0);
    @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) vcount++;
    end
    chk("arst_no_valid", 64'(vcount), 64'd0);
    issue(CTL_MFHI, 32'h0, 32'h0, 5'd0);
    chk("arst_hi", 64'(bus.result), 64'h0);
    issue(CTL_MFLO, 32'h0, 32'h0, 5'd0);
    chk("arst_lo", 64'(bus.result), 64'h0);
    chk("arst_lo_zero", 64'(bus.zero), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
